// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory read arbiter.
// Holds the FSM state encoding and a safe index-width helper.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND,
        ST_RECOVER
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick, combinational: searches upward from i_last_grant+1 with wrap.
// Returns one-hot grant, its index, and whether any request was present.
module rr_select
    import mem_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);

    logic [IW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_pos       = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IW'((32'(i_last_grant) + 32'(k)) % 32'(N));
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_grant_idx    = w_pos;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// N-to-1 read arbiter, one outstanding read; slave valid -> requester valid in 1 cycle.
// Requesters are held off by req_waitrequest outside IDLE; the slave stalls issue via m_waitrequest.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [NUM_REQ-1:0]        req_error,
    output logic [ADDR_W-1:0]         m_address,
    output logic                      m_read,
    input  logic                      m_waitrequest,
    input  logic [DATA_W-1:0]         m_readdata,
    input  logic                      m_readdatavalid
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = idx_w(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t r_state, w_state_nxt;

    logic [IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0] r_grant_oh;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_m_address;
    logic               r_m_read;
    logic [DATA_W-1:0]  r_readdata;
    logic [NUM_REQ-1:0] r_rdv;
    logic [NUM_REQ-1:0] r_err;

    logic [NUM_REQ-1:0] w_grant_oh;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any;
    logic               w_accept;
    logic               w_timeout;
    logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
        assign w_addr_arr[gi] = req_address[gi*ADDR_W +: ADDR_W];
    end

    rr_select #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
        .i_req        (req_read),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:   if (!m_waitrequest) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (m_readdatavalid) begin
                    w_state_nxt = ST_RESPOND;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RECOVER;
                end
            end
            ST_RESPOND: w_state_nxt = ST_IDLE;
            // A single late response is swallowed here so it can't leak into the next grant.
            ST_RECOVER: if (m_readdatavalid || r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= LAST_RST;
            r_grant_oh   <= '0;
            r_cnt        <= '0;
            r_m_address  <= '0;
            r_m_read     <= 1'b0;
            r_readdata   <= '0;
            r_rdv        <= '0;
            r_err        <= '0;
        end else begin
            r_m_read <= (r_state == ST_ISSUE) && !m_waitrequest;
            r_rdv    <= '0;
            r_err    <= '0;
            if (w_accept) begin
                r_m_address  <= w_addr_arr[w_grant_idx];
                r_grant_oh   <= w_grant_oh;
                r_last_grant <= w_grant_idx;
            end
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT || r_state == ST_RECOVER) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == ST_WAIT && m_readdatavalid) begin
                r_readdata <= m_readdata;
                r_rdv      <= r_grant_oh;
            end else if (w_timeout) begin
                r_readdata <= '0;
                r_rdv      <= r_grant_oh;
                r_err      <= r_grant_oh;
            end
        end
    end

    assign req_waitrequest   = req_read & ~({NUM_REQ{w_accept}} & w_grant_oh);
    assign req_readdata      = r_readdata;
    assign req_readdatavalid = r_rdv;
    assign req_error         = r_err;
    assign m_address         = r_m_address;
    assign m_read            = r_m_read;

endmodule
